convex_pt_sched: RTL and testbench

Point scheduler that sits in front of the CONVEX hull engine. It buffers 10-bit (X,Y) points arriving on a valid/ready port and serializes each one onto the engine's 5-bit PT_XY bus when the engine asserts READ_PT. It also tags every DROP point the engine reports with the ID of the point that caused the drop. Host-side logic sees a plain stream interface and never deals with the nibble protocol.

---
 rtl/convex_pkg.sv | 14 +
 rtl/convex_pt_fifo.sv | 37 +++
 rtl/convex_pt_sched.sv | 85 ++++++++
 tb/tb_convex_pt_sched.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/convex_pkg.sv
// convex_pkg: shared point type, widths and serializer slot codes for the CONVEX point scheduler
package convex_pkg;
  localparam int COORD_W = 10;
  localparam int SLICE_W = 5;
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pt_t;
  localparam logic [2:0] SLOT_IDLE = 3'd0;
  localparam logic [2:0] SLOT_YL   = 3'd1;
  localparam logic [2:0] SLOT_YH   = 3'd2;
  localparam logic [2:0] SLOT_XL   = 3'd3;
  localparam logic [2:0] SLOT_XH   = 3'd4;
endpackage

// File: rtl/convex_pt_fifo.sv
// convex_pt_fifo: synchronous FIFO with occupancy count, head word visible combinationally
module convex_pt_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  assign dout_o = mem_q[rd_q];
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= push_i ? wr_q + 1'b1 : wr_q;
      rd_q <= pop_i ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
endmodule

// File: rtl/convex_pt_sched.sv
// convex_pt_sched: buffers host points, serializes them as 4 slices on PT_XY, tags engine drops with the delivered-point count
module convex_pt_sched
  import convex_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [COORD_W-1:0] IN_X,
  input  logic [COORD_W-1:0] IN_Y,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic               READ_PT,
  output logic [SLICE_W-1:0] PT_XY,
  input  logic [COORD_W-1:0] DROP_X,
  input  logic [COORD_W-1:0] DROP_Y,
  input  logic               DROP_V,
  output logic               OUT_DROP_V,
  output logic [COORD_W-1:0] OUT_DROP_X,
  output logic [COORD_W-1:0] OUT_DROP_Y,
  output logic [ID_W-1:0]    OUT_DROP_ID,
  output logic [ID_W-1:0]    PT_CNT,
  output logic               BUSY
);
  pt_t head, src, sr_q;
  logic full, empty, start, push;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  logic [2:0] slot_q, slot_d;
  logic [SLICE_W-1:0] pt_xy_q, pt_xy_d;
  logic [ID_W-1:0] pt_cnt_q, drop_id_q;
  logic [COORD_W-1:0] drop_x_q, drop_y_q;
  logic drop_v_q;
  assign push = IN_VALID && !full;
  assign start = READ_PT && (slot_q == SLOT_IDLE || slot_q == SLOT_YL) && !empty;
  convex_pt_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(pt_t))) u_fifo (
    .clk(CLK),
    .rst(RST),
    .push_i(push),
    .pop_i(start),
    .din_i({IN_X, IN_Y}),
    .dout_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(fifo_cnt)
  );
  // Slice is chosen from the next slot so PT_XY lines up with SLOT
  assign src = start ? head : sr_q;
  always_comb begin
    slot_d = start ? SLOT_XH : slot_q > SLOT_YL ? slot_q - 3'd1 : SLOT_IDLE;
    pt_xy_d = slot_d == SLOT_XH ? src.x[COORD_W-1:SLICE_W] :
              slot_d == SLOT_XL ? src.x[SLICE_W-1:0] :
              slot_d == SLOT_YH ? src.y[COORD_W-1:SLICE_W] :
              slot_d == SLOT_YL ? src.y[SLICE_W-1:0] : '0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_q <= SLOT_IDLE;
      sr_q <= '0;
      pt_xy_q <= '0;
      pt_cnt_q <= '0;
      drop_v_q <= 1'b0;
      drop_x_q <= '0;
      drop_y_q <= '0;
      drop_id_q <= '0;
    end else begin
      slot_q <= slot_d;
      sr_q <= src;
      pt_xy_q <= pt_xy_d;
      pt_cnt_q <= slot_q == SLOT_YL ? pt_cnt_q + 1'b1 : pt_cnt_q;
      drop_v_q <= DROP_V;
      drop_x_q <= DROP_V ? DROP_X : drop_x_q;
      drop_y_q <= DROP_V ? DROP_Y : drop_y_q;
      drop_id_q <= DROP_V ? pt_cnt_q : drop_id_q;
    end
  end
  assign IN_READY = !full;
  assign PT_XY = pt_xy_q;
  assign PT_CNT = pt_cnt_q;
  assign OUT_DROP_V = drop_v_q;
  assign OUT_DROP_X = drop_x_q;
  assign OUT_DROP_Y = drop_y_q;
  assign OUT_DROP_ID = drop_id_q;
  assign BUSY = slot_q != SLOT_IDLE || fifo_cnt != '0;
endmodule

// File: tb/tb_convex_pt_sched.sv
// tb_convex_pt_sched: directed scenario tasks with hand-computed slice, count and drop-tag expectations
module tb_convex_pt_sched;
  logic CLK = 0, RST = 1;
  logic [9:0] IN_X = 0, IN_Y = 0, DROP_X = 0, DROP_Y = 0;
  logic IN_VALID = 0, READ_PT = 0, DROP_V = 0;
  logic IN_READY, OUT_DROP_V, BUSY;
  logic [4:0] PT_XY;
  logic [9:0] OUT_DROP_X, OUT_DROP_Y;
  logic [7:0] OUT_DROP_ID, PT_CNT;
  int total = 0, bad = 0;

  convex_pt_sched dut (
    .CLK(CLK), .RST(RST), .IN_X(IN_X), .IN_Y(IN_Y), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .READ_PT(READ_PT), .PT_XY(PT_XY), .DROP_X(DROP_X),
    .DROP_Y(DROP_Y), .DROP_V(DROP_V), .OUT_DROP_V(OUT_DROP_V), .OUT_DROP_X(OUT_DROP_X),
    .OUT_DROP_Y(OUT_DROP_Y), .OUT_DROP_ID(OUT_DROP_ID), .PT_CNT(PT_CNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1; IN_VALID = 0; READ_PT = 0; DROP_V = 0;
    step; step;
    RST = 0;
  endtask

  task automatic push_pt(input logic [9:0] x, input logic [9:0] y);
    IN_X = x; IN_Y = y; IN_VALID = 1;
    step;
    IN_VALID = 0;
  endtask

  task automatic test_reset;
    do_reset;
    total++; if (PT_XY !== 5'd0) begin bad++; $display("FAIL reset_pt_xy got=%0d exp=0", PT_XY); end
    total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", IN_READY); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", BUSY); end
    total++; if (PT_CNT !== 8'd0) begin bad++; $display("FAIL reset_pt_cnt got=%0d exp=0", PT_CNT); end
    total++; if (OUT_DROP_V !== 1'b0 || OUT_DROP_ID !== 8'd0 || OUT_DROP_X !== 10'd0 || OUT_DROP_Y !== 10'd0) begin
      bad++; $display("FAIL reset_drop got v=%0b id=%0d x=%0d y=%0d exp all 0", OUT_DROP_V, OUT_DROP_ID, OUT_DROP_X, OUT_DROP_Y);
    end
  endtask

  task automatic test_single;
    logic [4:0] exp [4] = '{5'd3, 5'd4, 5'd6, 5'd8};
    do_reset;
    push_pt(10'd100, 10'd200);
    READ_PT = 1;
    total++; if (PT_XY !== 5'd0 || BUSY !== 1'b1) begin bad++; $display("FAIL single_pre got xy=%0d busy=%0b exp 0/1", PT_XY, BUSY); end
    for (int i = 0; i < 4; i++) begin
      step;
      total++; if (PT_XY !== exp[i]) begin bad++; $display("FAIL single_slice%0d got=%0d exp=%0d", i, PT_XY, exp[i]); end
    end
    total++; if (PT_CNT !== 8'd0) begin bad++; $display("FAIL single_cnt_mid got=%0d exp=0", PT_CNT); end
    READ_PT = 0;
    step;
    total++; if (PT_XY !== 5'd0 || PT_CNT !== 8'd1 || BUSY !== 1'b0) begin
      bad++; $display("FAIL single_end got xy=%0d cnt=%0d busy=%0b exp 0/1/0", PT_XY, PT_CNT, BUSY);
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp [12] = '{5'd3, 5'd4, 5'd6, 5'd8, 5'd1, 5'd1, 5'd2, 5'd2, 5'd16, 5'd0, 5'd0, 5'd31};
    do_reset;
    push_pt(10'd100, 10'd200);
    push_pt(10'd33, 10'd66);
    push_pt(10'd512, 10'd31);
    READ_PT = 1;
    for (int i = 0; i < 12; i++) begin
      step;
      total++; if (PT_XY !== exp[i] || BUSY !== 1'b1) begin
        bad++; $display("FAIL b2b_slice%0d got=%0d busy=%0b exp=%0d busy=1", i, PT_XY, BUSY, exp[i]);
      end
    end
    step;
    READ_PT = 0;
    total++; if (PT_CNT !== 8'd3 || PT_XY !== 5'd0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL b2b_end got cnt=%0d xy=%0d busy=%0b exp 3/0/0", PT_CNT, PT_XY, BUSY);
    end
  endtask

  task automatic test_pending;
    logic [4:0] exp [4] = '{5'd31, 5'd31, 5'd0, 5'd0};
    do_reset;
    READ_PT = 1;
    for (int i = 0; i < 5; i++) begin
      step;
      total++; if (PT_XY !== 5'd0 || BUSY !== 1'b0) begin bad++; $display("FAIL pend_idle%0d got xy=%0d busy=%0b exp 0/0", i, PT_XY, BUSY); end
    end
    push_pt(10'd1023, 10'd0);
    total++; if (PT_XY !== 5'd0 || BUSY !== 1'b1) begin bad++; $display("FAIL pend_pushed got xy=%0d busy=%0b exp 0/1", PT_XY, BUSY); end
    for (int i = 0; i < 4; i++) begin
      step;
      total++; if (PT_XY !== exp[i] || BUSY !== 1'b1) begin bad++; $display("FAIL pend_slice%0d got=%0d busy=%0b exp=%0d busy=1", i, PT_XY, BUSY, exp[i]); end
    end
    step;
    READ_PT = 0;
    total++; if (PT_CNT !== 8'd1 || BUSY !== 1'b0) begin bad++; $display("FAIL pend_end got cnt=%0d busy=%0b exp 1/0", PT_CNT, BUSY); end
  endtask

  task automatic test_full;
    do_reset;
    for (int i = 1; i <= 4; i++) begin
      total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL full_ready_pre%0d got=%0b exp=1", i, IN_READY); end
      push_pt(10'(i * 32), 10'd0);
    end
    total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b exp=0", IN_READY); end
    push_pt(10'd192, 10'd0);
    total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL full_ignored got=%0b exp=0", IN_READY); end
    READ_PT = 1;
    step;
    READ_PT = 0;
    total++; if (IN_READY !== 1'b1 || PT_XY !== 5'd1) begin bad++; $display("FAIL full_pop got ready=%0b xy=%0d exp 1/1", IN_READY, PT_XY); end
    step; step; step;
    IN_X = 10'd160; IN_Y = 10'd0; IN_VALID = 1; READ_PT = 1;
    step;
    IN_VALID = 0;
    total++; if (IN_READY !== 1'b1 || PT_XY !== 5'd2) begin bad++; $display("FAIL full_pushpop got ready=%0b xy=%0d exp 1/2", IN_READY, PT_XY); end
    for (int k = 3; k <= 5; k++) begin
      step; step; step; step;
      total++; if (PT_XY !== 5'(k)) begin bad++; $display("FAIL full_order%0d got=%0d exp=%0d", k, PT_XY, k); end
    end
    step; step; step; step;
    READ_PT = 0;
    total++; if (BUSY !== 1'b0 || PT_XY !== 5'd0 || PT_CNT !== 8'd5) begin
      bad++; $display("FAIL full_drain got busy=%0b xy=%0d cnt=%0d exp 0/0/5", BUSY, PT_XY, PT_CNT);
    end
  endtask

  task automatic test_drop;
    do_reset;
    push_pt(10'd100, 10'd200);
    push_pt(10'd33, 10'd66);
    push_pt(10'd512, 10'd31);
    READ_PT = 1;
    for (int i = 0; i < 9; i++) step;
    total++; if (PT_CNT !== 8'd2) begin bad++; $display("FAIL drop_cnt2 got=%0d exp=2", PT_CNT); end
    DROP_V = 1; DROP_X = 10'd50; DROP_Y = 10'd60;
    step;
    total++; if (OUT_DROP_V !== 1'b1 || OUT_DROP_X !== 10'd50 || OUT_DROP_Y !== 10'd60 || OUT_DROP_ID !== 8'd2) begin
      bad++; $display("FAIL drop_first got v=%0b x=%0d y=%0d id=%0d exp 1/50/60/2", OUT_DROP_V, OUT_DROP_X, OUT_DROP_Y, OUT_DROP_ID);
    end
    DROP_X = 10'd70; DROP_Y = 10'd80;
    step;
    DROP_V = 0;
    total++; if (OUT_DROP_V !== 1'b1 || OUT_DROP_X !== 10'd70 || OUT_DROP_Y !== 10'd80 || OUT_DROP_ID !== 8'd2) begin
      bad++; $display("FAIL drop_second got v=%0b x=%0d y=%0d id=%0d exp 1/70/80/2", OUT_DROP_V, OUT_DROP_X, OUT_DROP_Y, OUT_DROP_ID);
    end
    step;
    total++; if (OUT_DROP_V !== 1'b0 || PT_XY !== 5'd31) begin bad++; $display("FAIL drop_gap got v=%0b xy=%0d exp 0/31", OUT_DROP_V, PT_XY); end
    DROP_V = 1; DROP_X = 10'd90; DROP_Y = 10'd100;
    step;
    total++; if (OUT_DROP_V !== 1'b1 || OUT_DROP_ID !== 8'd2 || PT_CNT !== 8'd3) begin
      bad++; $display("FAIL drop_coincident got v=%0b id=%0d cnt=%0d exp 1/2/3", OUT_DROP_V, OUT_DROP_ID, PT_CNT);
    end
    DROP_X = 10'd5; DROP_Y = 10'd6;
    step;
    DROP_V = 0; READ_PT = 0;
    total++; if (OUT_DROP_V !== 1'b1 || OUT_DROP_ID !== 8'd3 || OUT_DROP_X !== 10'd5) begin
      bad++; $display("FAIL drop_after got v=%0b id=%0d x=%0d exp 1/3/5", OUT_DROP_V, OUT_DROP_ID, OUT_DROP_X);
    end
    step;
    total++; if (OUT_DROP_V !== 1'b0) begin bad++; $display("FAIL drop_idle got=%0b exp=0", OUT_DROP_V); end
  endtask

  task automatic test_rst_mid;
    logic [4:0] exp [4] = '{5'd16, 5'd0, 5'd0, 5'd31};
    do_reset;
    push_pt(10'd100, 10'd200);
    push_pt(10'd33, 10'd66);
    READ_PT = 1;
    step; step;
    total++; if (PT_XY !== 5'd4) begin bad++; $display("FAIL rst_mid_slot3 got=%0d exp=4", PT_XY); end
    RST = 1;
    step;
    RST = 0; READ_PT = 0;
    total++; if (PT_XY !== 5'd0 || BUSY !== 1'b0 || PT_CNT !== 8'd0 || IN_READY !== 1'b1) begin
      bad++; $display("FAIL rst_mid_state got xy=%0d busy=%0b cnt=%0d ready=%0b exp 0/0/0/1", PT_XY, BUSY, PT_CNT, IN_READY);
    end
    push_pt(10'd512, 10'd31);
    READ_PT = 1;
    for (int i = 0; i < 4; i++) begin
      step;
      total++; if (PT_XY !== exp[i]) begin bad++; $display("FAIL rst_mid_slice%0d got=%0d exp=%0d", i, PT_XY, exp[i]); end
    end
    READ_PT = 0;
    step;
    total++; if (PT_CNT !== 8'd1 || BUSY !== 1'b0) begin bad++; $display("FAIL rst_mid_end got cnt=%0d busy=%0b exp 1/0", PT_CNT, BUSY); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_pending;
    test_full;
    test_drop;
    test_rst_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
